// File: rtl/regfile_write_sequencer.sv
// Write-side sequencer for the 4x8 sync register file: request FIFO feeding a SETUP/STROBE/RECOVER strobe FSM.
// Define REGFILE_WRSEQ_FWD_EN to enable pending-write bypass on the fwdL_*/fwdR_* ports.
module regfile_write_sequencer #(
  parameter int LOG          = 0,
  parameter int DEPTH        = 4,
  parameter int PULSE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       MR,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_data,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       _wr_en,
  output logic       busy,
  input  logic [1:0] rdL_addr,
  input  logic [1:0] rdR_addr,
  output logic       fwdL_hit,
  output logic [7:0] fwdL_data,
  output logic       fwdR_hit,
  output logic [7:0] fwdR_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam bit LOG_ON = (LOG != 0);

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  entry_t [DEPTH-1:0] r_mem;
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [CW-1:0]      r_count;
  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_pcnt;
  logic [1:0]         r_wr_addr;
  logic [7:0]         r_wr_data;
  logic               r_wr_en_n;
  logic               w_push, w_pop, w_nempty;

  assign w_nempty  = (r_count != '0);
  assign req_ready = (r_count != CW'(DEPTH)) && !MR;
  assign w_push    = req_valid && req_ready;

  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign _wr_en  = r_wr_en_n;
  assign busy    = w_nempty || (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP:  w_state_nxt = STROBE;
      STROBE: if (r_pcnt == '0) w_state_nxt = RECOVER;
      RECOVER: begin
        w_state_nxt = IDLE;
        if (w_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage needs no reset: count/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {req_addr, req_data};
  end

  always_ff @(posedge clk) begin
    if (MR) begin
      r_state   <= IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_pcnt    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en_n <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      // Strobe is derived from the next state so it only ever falls on the SETUP->STROBE edge.
      r_wr_en_n <= (w_state_nxt != STROBE);
      if (w_pop) begin
        r_wr_addr <= r_mem[r_rptr].addr;
        r_wr_data <= r_mem[r_rptr].data;
        r_rptr    <= r_rptr + 1'b1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_state == SETUP)
        r_pcnt <= PW'(PULSE_CYCLES - 1);
      else if (r_state == STROBE && r_pcnt != '0)
        r_pcnt <= r_pcnt - 1'b1;
    end
  end

`ifdef REGFILE_WRSEQ_FWD_EN
  // Later matches override earlier ones: in-flight first, then FIFO head to tail.
  function automatic logic [8:0] f_lookup(
    input logic [1:0]         a,
    input entry_t [DEPTH-1:0] mem,
    input logic [AW-1:0]      rptr,
    input logic [CW-1:0]      cnt,
    input logic               infl,
    input entry_t             cur
  );
    logic [8:0]    res;
    logic [AW-1:0] idx;
    res = '0;
    if (infl && cur.addr == a) res = {1'b1, cur.data};
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + AW'(i);
      if (CW'(i) < cnt && mem[idx].addr == a) res = {1'b1, mem[idx].data};
    end
    return res;
  endfunction

  logic   w_inflight;
  entry_t w_cur;
  logic   w_unused;

  assign w_inflight = (r_state == SETUP) || (r_state == STROBE);
  assign w_cur      = '{addr: r_wr_addr, data: r_wr_data};
  assign {fwdL_hit, fwdL_data} = f_lookup(rdL_addr, r_mem, r_rptr, r_count, w_inflight, w_cur);
  assign {fwdR_hit, fwdR_data} = f_lookup(rdR_addr, r_mem, r_rptr, r_count, w_inflight, w_cur);
  assign w_unused = LOG_ON;
`else
  logic w_unused;

  assign fwdL_hit  = 1'b0;
  assign fwdL_data = 8'h00;
  assign fwdR_hit  = 1'b0;
  assign fwdR_data = 8'h00;
  assign w_unused  = ^{rdL_addr, rdR_addr, LOG_ON};
`endif

endmodule
